// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and constants for the 4-channel scan sequencer.
//   scan_state_t : sequencer FSM states (IDLE, DWELL, BLANK)
//   NUM_CH       : number of scanned channels
//   SEL_W        : width of the channel select
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_next_ch.sv
// -----------------------------------------------------------------------------
// scan_next_ch
// Combinational round-robin search for the next enabled channel.
// Ports:
//   cur_sel   in   SEL_W   channel the search starts after
//   ch_mask   in   NUM_CH  bit i=1 means channel i is eligible
//   nxt_sel   out  SEL_W   first set channel among cur_sel+1..cur_sel+4 (mod 4)
//   nxt_valid out  1       at least one channel is eligible
//   wrap      out  1       nxt_sel <= cur_sel (the search wrapped or repeated)
// Feeding cur_sel = all-ones turns the search into "lowest set bit".
// -----------------------------------------------------------------------------
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_sel,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  nxt_sel,
    output logic              nxt_valid,
    output logic              wrap
);

    always_comb begin
        nxt_sel = cur_sel;
        // Walk from the farthest offset to the nearest so the nearest set
        // channel is the last one written and therefore wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            logic [SEL_W-1:0] idx;
            idx = cur_sel + SEL_W'(k);
            if (ch_mask[idx]) begin
                nxt_sel = idx;
            end
        end
        nxt_valid = |ch_mask;
        wrap      = (nxt_sel <= cur_sel);
    end

endmodule

// File: rtl/scan_sequencer_4ch.sv
// -----------------------------------------------------------------------------
// scan_sequencer_4ch
// Drives the select/enable of a 2:4 one-hot decoder. Visits the channels set
// in ch_mask round-robin, holding each enabled for DWELL_CYCLES cycles and
// then blanking the enable for BLANK_CYCLES cycles to avoid ghosting.
// Parameters:
//   DWELL_CYCLES  cycles with en=1 per visit (>=1)
//   BLANK_CYCLES  cycles with en=0 after each dwell (>=0, 0 = no gap)
//   CNT_W         width of the internal cycle counter
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   run         in   1   level, 1 = scan, 0 = stop
//   ch_mask     in   4   channel participation mask
//   sel         out  2   registered channel select
//   en          out  1   registered decoder enable
//   frame_done  out  1   one-cycle pulse after each frame-end advance
// Build option:
//   SCAN_FRAME_PULSE_EN  when defined, adds the frame_done port and flop.
// -----------------------------------------------------------------------------
module scan_sequencer_4ch
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int CNT_W        = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  sel,
`ifdef SCAN_FRAME_PULSE_EN
    output logic              en,
    output logic              frame_done
`else
    output logic              en
`endif
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    scan_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel;
    logic              r_en;

    logic [SEL_W-1:0]  w_cur_sel;
    logic [SEL_W-1:0]  w_nxt_sel;
    logic              w_nxt_valid;
    logic              w_dwell_end;
    logic              w_blank_end;
    logic              w_advance;

    // In IDLE the search starts "after channel 3", yielding the lowest set
    // channel, so a restart never resumes from the last visited channel.
    assign w_cur_sel = (r_state == IDLE) ? {SEL_W{1'b1}} : r_sel;

`ifdef SCAN_FRAME_PULSE_EN
    logic w_wrap;
    logic r_frame_done;

    scan_next_ch u_next_ch (
        .cur_sel   (w_cur_sel),
        .ch_mask   (ch_mask),
        .nxt_sel   (w_nxt_sel),
        .nxt_valid (w_nxt_valid),
        .wrap      (w_wrap)
    );
`else
    scan_next_ch u_next_ch (
        .cur_sel   (w_cur_sel),
        .ch_mask   (ch_mask),
        .nxt_sel   (w_nxt_sel),
        .nxt_valid (w_nxt_valid),
        .wrap      ()
    );
`endif

    assign w_dwell_end = (r_state == DWELL) && (r_cnt == DWELL_LAST);
    assign w_blank_end = (r_state == BLANK) && (r_cnt == BLANK_LAST);
    // With no blank gap the dwell end advances directly, en stays high.
    assign w_advance   = w_blank_end || (w_dwell_end && (BLANK_CYCLES == 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
`ifdef SCAN_FRAME_PULSE_EN
            r_frame_done <= 1'b0;
`endif
        end else begin
`ifdef SCAN_FRAME_PULSE_EN
            // Single-cycle pulse; only a frame-end advance raises it.
            r_frame_done <= 1'b0;
`endif
            if (r_state == IDLE) begin
                r_en <= 1'b0;
                if (run && w_nxt_valid) begin
                    r_sel   <= w_nxt_sel;
                    r_en    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= DWELL;
                end
            end else if (!run) begin
                // Stop takes priority over the counter expiring this cycle.
                r_en    <= 1'b0;
                r_cnt   <= '0;
                r_state <= IDLE;
            end else if (w_advance) begin
                r_cnt <= '0;
                if (w_nxt_valid) begin
                    r_sel   <= w_nxt_sel;
                    r_en    <= 1'b1;
                    r_state <= DWELL;
`ifdef SCAN_FRAME_PULSE_EN
                    r_frame_done <= w_wrap;
`endif
                end else begin
                    r_en    <= 1'b0;
                    r_state <= IDLE;
                end
            end else if (w_dwell_end) begin
                r_en    <= 1'b0;
                r_cnt   <= '0;
                r_state <= BLANK;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sel = r_sel;
    assign en  = r_en;
`ifdef SCAN_FRAME_PULSE_EN
    assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_scan_sequencer_4ch.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer_4ch
// Directed bench for scan_sequencer_4ch. Two instances: the default timing
// (DWELL=4, BLANK=1) and a no-gap variant (DWELL=4, BLANK=0).
// frame_done is checked only when SCAN_FRAME_PULSE_EN is defined.
// -----------------------------------------------------------------------------
module tb_scan_sequencer_4ch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, run_nb;
    logic [3:0] mask, mask_nb;
    logic [1:0] sel, sel_nb;
    logic       en, en_nb;
`ifdef SCAN_FRAME_PULSE_EN
    logic       fd, fd_nb;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    scan_sequencer_4ch #(.DWELL_CYCLES(4), .BLANK_CYCLES(1), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ch_mask    (mask),
        .sel        (sel),
`ifdef SCAN_FRAME_PULSE_EN
        .en         (en),
        .frame_done (fd)
`else
        .en         (en)
`endif
    );

    scan_sequencer_4ch #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(16)) u_dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_nb),
        .ch_mask    (mask_nb),
        .sel        (sel_nb),
`ifdef SCAN_FRAME_PULSE_EN
        .en         (en_nb),
        .frame_done (fd_nb)
`else
        .en         (en_nb)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks t=0..n-1 of a scan started on the edge just before t=0.
    // Steps between samples but not after the last one.
    task automatic check_scan(input string tag, input int n, input int dw, input int bl,
                              input logic [1:0] ord [4], input int nord, input bit nb);
        int slot;
        int ph;
        int k;
        slot = dw + bl;
        for (int t = 0; t < n; t++) begin
            if (t > 0) step();
            ph = t % slot;
            k  = (t / slot) % nord;
            if (nb) begin
                chk($sformatf("%s_en_t%0d", tag, t), 32'(en_nb), 32'(ph < dw));
                chk($sformatf("%s_sel_t%0d", tag, t), 32'(sel_nb), 32'(ord[k]));
`ifdef SCAN_FRAME_PULSE_EN
                chk($sformatf("%s_fd_t%0d", tag, t), 32'(fd_nb),
                    32'((t > 0) && (t % (slot * nord) == 0)));
`endif
            end else begin
                chk($sformatf("%s_en_t%0d", tag, t), 32'(en), 32'(ph < dw));
                chk($sformatf("%s_sel_t%0d", tag, t), 32'(sel), 32'(ord[k]));
`ifdef SCAN_FRAME_PULSE_EN
                chk($sformatf("%s_fd_t%0d", tag, t), 32'(fd),
                    32'((t > 0) && (t % (slot * nord) == 0)));
`endif
            end
        end
    endtask

    initial begin
        logic [1:0] ord_all [4];
        logic [1:0] ord_13  [4];
        logic [1:0] ord_2   [4];
        ord_all = '{2'd0, 2'd1, 2'd2, 2'd3};
        ord_13  = '{2'd1, 2'd3, 2'd0, 2'd0};
        ord_2   = '{2'd2, 2'd0, 2'd0, 2'd0};

        rst_n   = 1'b0;
        run     = 1'b0;
        run_nb  = 1'b0;
        mask    = 4'b0000;
        mask_nb = 4'b0000;
        step();
        step();
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_nb_en", 32'(en_nb), 32'd0);
`ifdef SCAN_FRAME_PULSE_EN
        chk("reset_fd", 32'(fd), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("idle_en", 32'(en), 32'd0);

        // Full mask: en 1111_0, sel 0,1,2,3,0
        mask = 4'b1111;
        run  = 1'b1;
        step();
        check_scan("full", 25, 4, 1, ord_all, 4, 1'b0);
        run = 1'b0;
        step();
        chk("full_stop_en", 32'(en), 32'd0);
        chk("full_stop_sel", 32'(sel), 32'd0);

        // Mask 1010: channels 1 and 3 only
        mask = 4'b1010;
        run  = 1'b1;
        step();
        check_scan("m1010", 20, 4, 1, ord_13, 2, 1'b0);
        run = 1'b0;
        step();
        chk("m1010_stop_en", 32'(en), 32'd0);
        chk("m1010_stop_sel", 32'(sel), 32'd3);

        // Single channel 2 repeats with its blank gap
        mask = 4'b0100;
        run  = 1'b1;
        step();
        check_scan("m0100", 15, 4, 1, ord_2, 1, 1'b0);
        run = 1'b0;
        step();
        chk("m0100_stop_en", 32'(en), 32'd0);
        chk("m0100_stop_sel", 32'(sel), 32'd2);

        // run drops on the 2nd dwell cycle of ch1, then restart at ch0
        mask = 4'b1111;
        run  = 1'b1;
        step();
        check_scan("pre_drop", 7, 4, 1, ord_all, 4, 1'b0);
        run = 1'b0;
        step();
        chk("drop_en", 32'(en), 32'd0);
        chk("drop_sel", 32'(sel), 32'd1);
        step();
        chk("drop_hold_en", 32'(en), 32'd0);
        chk("drop_hold_sel", 32'(sel), 32'd1);
        run = 1'b1;
        step();

        // Mask cleared during ch2 dwell: visit completes, then IDLE
        check_scan("restart", 12, 4, 1, ord_all, 4, 1'b0);
        mask = 4'b0000;
        step();
        chk("clr_t12_en", 32'(en), 32'd1);
        chk("clr_t12_sel", 32'(sel), 32'd2);
        step();
        chk("clr_t13_en", 32'(en), 32'd1);
        chk("clr_t13_sel", 32'(sel), 32'd2);
        step();
        chk("clr_t14_en", 32'(en), 32'd0);
        chk("clr_t14_sel", 32'(sel), 32'd2);
        step();
        chk("clr_t15_en", 32'(en), 32'd0);
        chk("clr_t15_sel", 32'(sel), 32'd2);
        step();
        step();
        chk("idle_mask0_en", 32'(en), 32'd0);
        chk("idle_mask0_sel", 32'(sel), 32'd2);
        run = 1'b0;

        // No blank gap: en stays high, sel changes every 4 cycles
        mask_nb = 4'b1111;
        run_nb  = 1'b1;
        step();
        check_scan("noblank", 17, 4, 0, ord_all, 4, 1'b1);
        run_nb = 1'b0;
        step();
        chk("noblank_stop_en", 32'(en_nb), 32'd0);

        // Asynchronous reset between edges while scanning ch1
        mask = 4'b1111;
        run  = 1'b1;
        step();
        check_scan("pre_rst", 7, 4, 1, ord_all, 4, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_en", 32'(en), 32'd0);
`ifdef SCAN_FRAME_PULSE_EN
        chk("arst_fd", 32'(fd), 32'd0);
`endif
        step();
        chk("arst_hold_en", 32'(en), 32'd0);
        rst_n = 1'b1;
        run   = 1'b0;
        step();
        chk("post_rst_en", 32'(en), 32'd0);
        chk("post_rst_sel", 32'(sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
